fpga_robots_game_uart_tx: RTL and testbench
===========================================

Name: fpga_robots_game_uart_tx

Overview:
Serial transmitter for the host link. It drives the `serial_tx` pin, which is currently tied idle-high. Game logic pushes bytes into a small internal FIFO. The block sends them as 8-N-1 asynchronous serial frames, with bit timing taken from the `baud1` strobe (115200 bit/s) produced by the clock block. It sits at top level beside the video and audio logic and is the outbound counterpart of the `serial_rx` path.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW entries (16).
- STOP_BITS, 1: number of stop bits, 1 or 2; any other value is illegal.
- PARITY_ODD, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock (~65MHz).
- rst_n  in  1  asynchronous active-low reset.
- baud1  in  1  one-clk strobe at bit rate; all line transitions align to it.
- wr_dat  in  8  byte to enqueue.
- wr_en  in  1  enqueue request; accepted only when wr_rdy=1.
- wr_rdy  out  1  FIFO not full.
- fifo_cnt  out  FIFO_AW+1  current FIFO occupancy.
- busy  out  1  frame in progress or FIFO non-empty.
- ovf  out  1  sticky flag: wr_en asserted while wr_rdy=0.
- tx  out  1  serial line; idle high.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values, applied asynchronously on rst_n low:
  - tx=1, wr_rdy=1, fifo_cnt=0, busy=0, ovf=0.
  - state=IDLE, FIFO pointers 0.
  - Release is synchronous to clk.
- Reset mid-frame: the frame is abandoned, tx returns to 1 immediately, and FIFO contents are discarded.
- FIFO:
  - A write occurs when wr_en && wr_rdy at a clk edge.
  - Pop happens only on entry to START.
  - Write and pop in the same cycle leave fifo_cnt unchanged.
  - wr_rdy = (fifo_cnt != 2**FIFO_AW), combinational from registered count. A full FIFO rejects a write even if a pop occurs in that same cycle.
  - Pointers wrap modulo depth.
  - Rejected write: data dropped, ovf set; ovf is cleared only by reset.
- FSM; all transitions occur only on cycles with baud1=1 and are evaluated on registered state:
  - IDLE: tx=1. On baud1 with fifo_cnt!=0, pop the head into shift register sh, go to START.
  - START: tx=0 for one baud period. On baud1, go to DATA with bitctr=0.
  - DATA: tx=sh[0], LSB first. On baud1, shift right and increment bitctr. After bit 7 (bitctr==7), go to PAR if parity is enabled, otherwise STOP.
  - STOP: tx=1. On baud1, count stop bits. When STOP_BITS have elapsed, go to IDLE.
- Back-to-back frames: if the FIFO is non-empty when STOP completes, the transition goes to START directly (popping the next byte), with no extra idle period.
- tx is a register updated on the same edge as the state change. Each bit lasts exactly one baud1 period.
- Latency: a byte written in cycle N into an empty FIFO with an idle FSM starts its start bit at the first baud1 strobe in cycle >= N+1. A baud1 coinciding with the write itself does not pop it.
- busy = (state!=IDLE) || (fifo_cnt!=0).
- baud1 asserted for more than one consecutive cycle is out of contract; each asserted cycle counts as one bit time.

Optional Feature:
- Macro: FPGA_ROBOTS_UART_PARITY_EN.
- Defined:
  - A PAR state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits, XOR PARITY_ODD, for one baud period.
  - Frame is 8-E-1 (or 8-O-1) and is 11 baud periods long with STOP_BITS=1.
- Undefined: no PAR state, frame is 10 baud periods, and PARITY_ODD is ignored.

Decomposition:
- Shared include fpga_robots_game_uart_defs.v holds:
  - state encodings (IDLE, START, DATA, PAR, STOP as 3-bit localparams);
  - UART_DBITS=8;
  - the bitctr width.
- The future receiver reuses the same include.
- One sub-module, fpga_robots_game_fifo_sync: a parameterised single-clock FIFO (distributed RAM, count output).
- Shift register and FSM stay in the top module.

Test Plan:
- Single byte, no parity: write 0x55 while idle, baud1 every 16 clk.
  - tx sequence per baud period is 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), then held at 1.
  - busy falls on the baud1 ending the stop bit.
- Back-to-back: write 0xA5 then 0x3C in consecutive cycles.
  - Two frames with no idle gap; second start bit begins on the same baud1 that ends the first stop bit.
  - fifo_cnt goes 1→2→1→0.
- Overflow: hold baud1=0 and write 17 bytes 0x00..0x10.
  - wr_rdy falls after the 16th write; 17th write sets ovf=1.
  - Release baud1: exactly 0x00..0x0F are transmitted, in order.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF with 5 bytes queued.
  - tx=1 asynchronously (before the next clk edge); fifo_cnt=0, ovf=0, busy=0.
  - No further frames after release.
- Parity: with FPGA_ROBOTS_UART_PARITY_EN and PARITY_ODD=0, send 0x07; with PARITY_ODD=1, send 0x07.
  - Parity bit is 1 for PARITY_ODD=0 and 0 for PARITY_ODD=1; frame is 11 periods.
- Stop bits and timing: with STOP_BITS=2, send 0x00 with baud1 coinciding with the wr_en cycle.
  - Start bit begins on the next baud1, not the coincident one.
  - Stop level 1 is held for exactly 2 baud periods.

Source files
------------

// File: rtl/fpga_robots_game_uart_tx_pkg.sv
// Shared UART definitions for the host serial link (transmitter now, receiver
// later): frame state encodings, data width, bit counter width and the parity
// helper. Configuration macro: FPGA_ROBOTS_UART_PARITY_EN (parity bit in frame).
package fpga_robots_game_uart_tx_pkg;

  localparam int UART_DBITS    = 8;
  localparam int UART_BITCTR_W = $clog2(UART_DBITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Parity bit for a data word; odd=1 makes the total count of ones odd.
  function automatic logic uart_parity(input logic [UART_DBITS-1:0] d,
                                       input logic                  odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/fpga_robots_game_fifo_sync.sv
// Single-clock FIFO with distributed-RAM storage and an occupancy count.
// Read data is combinational from the head entry (first-word fall-through).
// Ports:
//   clk, rst_n      clock, async active-low reset (pointers/count only)
//   i_wr_en/i_wr_dat write request and data; ignored when full
//   i_rd_en         pop request; ignored when empty
//   o_rd_dat        head entry
//   o_full/o_empty  status from the registered count
//   o_cnt           occupancy, 0..2**AW
module fpga_robots_game_fifo_sync #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_cnt
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_wr, w_rd;

  assign o_full   = (r_cnt == FULL_CNT);
  assign o_empty  = (r_cnt == '0);
  assign o_cnt    = r_cnt;
  assign o_rd_dat = r_mem[r_rptr];

  // Full check uses the registered count, so a full FIFO rejects a write
  // even when a pop happens on the same edge.
  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/fpga_robots_game_uart_tx.sv
// Host-link UART transmitter. Bytes pushed by game logic are queued in a small
// FIFO and sent as 8-N-1 frames (8-E-1 / 8-O-1 with parity compiled in), with
// every line transition aligned to the baud1 strobe.
// Configuration macro: FPGA_ROBOTS_UART_PARITY_EN inserts a parity bit.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   baud1       one-clk strobe per bit time
//   wr_dat/wr_en byte enqueue; accepted when wr_rdy=1
//   wr_rdy      FIFO not full
//   fifo_cnt    FIFO occupancy
//   busy        frame in flight or bytes queued
//   ovf         sticky: write attempted while full (cleared by reset only)
//   tx          serial line, idle high
module fpga_robots_game_uart_tx
  import fpga_robots_game_uart_tx_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud1,
  input  logic [7:0]       wr_dat,
  input  logic             wr_en,
  output logic             wr_rdy,
  output logic [FIFO_AW:0] fifo_cnt,
  output logic             busy,
  output logic             ovf,
  output logic             tx
);

  if ((STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("fpga_robots_game_uart_tx: STOP_BITS must be 1 or 2, PARITY_ODD 0 or 1");
  end

  localparam logic                     STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [UART_BITCTR_W-1:0] LAST_BIT  = UART_BITCTR_W'(UART_DBITS - 1);

  uart_state_e             r_state, w_state_nxt;
  logic [UART_DBITS-1:0]   r_sh, w_sh_nxt;
  logic [UART_BITCTR_W-1:0] r_bitctr, w_bitctr_nxt;
  logic                    r_stopctr, w_stopctr_nxt;
  logic                    r_tx, w_tx_nxt;
  logic                    r_ovf;
  logic                    w_pop;
  logic [UART_DBITS-1:0]   w_fifo_dat;
  logic                    w_full, w_empty;

  fpga_robots_game_fifo_sync #(
    .DW (UART_DBITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (wr_en),
    .i_wr_dat (wr_dat),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_fifo_dat),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_cnt    (fifo_cnt)
  );

  assign wr_rdy = ~w_full;
  assign busy   = (r_state != ST_IDLE) || !w_empty;
  assign ovf    = r_ovf;
  assign tx     = r_tx;

`ifdef FPGA_ROBOTS_UART_PARITY_EN
  // Parity is latched from the popped byte, since sh is consumed by shifting.
  logic r_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_par <= 1'b0;
    else if (w_pop) r_par <= uart_parity(w_fifo_dat, 1'(PARITY_ODD));
  end
`endif

  // Next-state logic; nothing moves except on a baud1 cycle. tx is computed
  // as the level for the coming bit period and registered with the state.
  always_comb begin
    w_state_nxt   = r_state;
    w_sh_nxt      = r_sh;
    w_bitctr_nxt  = r_bitctr;
    w_stopctr_nxt = r_stopctr;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    if (baud1) begin
      case (r_state)
        ST_IDLE: begin
          w_tx_nxt = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_sh_nxt    = w_fifo_dat;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end
        end
        ST_START: begin
          w_state_nxt  = ST_DATA;
          w_bitctr_nxt = '0;
          w_tx_nxt     = r_sh[0];
        end
        ST_DATA: begin
          w_sh_nxt     = r_sh >> 1;
          w_bitctr_nxt = r_bitctr + UART_BITCTR_W'(1);
          if (r_bitctr == LAST_BIT) begin
`ifdef FPGA_ROBOTS_UART_PARITY_EN
            w_state_nxt = ST_PAR;
            w_tx_nxt    = r_par;
`else
            w_state_nxt   = ST_STOP;
            w_stopctr_nxt = 1'b0;
            w_tx_nxt      = 1'b1;
`endif
          end else begin
            // sh[0] is on the line now; sh[1] becomes the next bit.
            w_tx_nxt = r_sh[1];
          end
        end
`ifdef FPGA_ROBOTS_UART_PARITY_EN
        ST_PAR: begin
          w_state_nxt   = ST_STOP;
          w_stopctr_nxt = 1'b0;
          w_tx_nxt      = 1'b1;
        end
`endif
        ST_STOP: begin
          w_tx_nxt = 1'b1;
          if (r_stopctr == STOP_LAST) begin
            // Chain straight into the next frame when bytes are waiting.
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_sh_nxt    = w_fifo_dat;
              w_state_nxt = ST_START;
              w_tx_nxt    = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_stopctr_nxt = r_stopctr + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sh      <= '0;
      r_bitctr  <= '0;
      r_stopctr <= 1'b0;
      r_tx      <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh      <= w_sh_nxt;
      r_bitctr  <= w_bitctr_nxt;
      r_stopctr <= w_stopctr_nxt;
      r_tx      <= w_tx_nxt;
      if (wr_en && w_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_uart_tx.sv
// Directed bench for fpga_robots_game_uart_tx. Two instances share all inputs:
// u_dut1 (1 stop bit, even parity) and u_dut2 (2 stop bits, odd parity).
module tb_fpga_robots_game_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       baud1 = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_dat = 8'h00;

  logic       wr_rdy1, busy1, ovf1, tx1;
  logic [4:0] cnt1;
  logic       wr_rdy2, busy2, ovf2, tx2;
  logic [4:0] cnt2;

  int tests = 0;
  int fails = 0;
  int bcnt  = 0;
  bit brun  = 1'b0;
  bit last_baud = 1'b0;

  always #5 clk = ~clk;

  fpga_robots_game_uart_tx #(.FIFO_AW(4), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .baud1(baud1), .wr_dat(wr_dat), .wr_en(wr_en),
    .wr_rdy(wr_rdy1), .fifo_cnt(cnt1), .busy(busy1), .ovf(ovf1), .tx(tx1));

  fpga_robots_game_uart_tx #(.FIFO_AW(4), .STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .baud1(baud1), .wr_dat(wr_dat), .wr_en(wr_en),
    .wr_rdy(wr_rdy2), .fifo_cnt(cnt2), .busy(busy2), .ovf(ovf2), .tx(tx2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and baud1 for
  // the next edge is set here (a strobe every 16 clocks while brun=1).
  task automatic clk1();
    last_baud = baud1;
    @(posedge clk);
    #1;
    if (brun) begin
      bcnt++;
      baud1 = (bcnt % 16 == 0);
    end else begin
      baud1 = 1'b0;
    end
  endtask

  task automatic next_baud(input string tag);
    int n = 0;
    do begin
      clk1();
      n++;
    end while (!last_baud && n < 40);
    if (!last_baud) chk({tag, "_baud_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic txo(input int d);
    return (d == 2) ? tx2 : tx1;
  endfunction
  function automatic logic busyo(input int d);
    return (d == 2) ? busy2 : busy1;
  endfunction
  function automatic logic [4:0] cnto(input int d);
    return (d == 2) ? cnt2 : cnt1;
  endfunction

  // Expects the very next baud edge to open a start bit, then checks the frame.
  task automatic check_frame(input int d, input logic [7:0] b, input int cnt_exp, input string tag);
    next_baud(tag);
    chk({tag, "_start"}, 32'(txo(d)), 32'd0);
    chk({tag, "_cnt"}, 32'(cnto(d)), 32'(cnt_exp));
    for (int i = 0; i < 8; i++) begin
      next_baud(tag);
      chk($sformatf("%s_d%0d", tag, i), 32'(txo(d)), 32'(b[i]));
    end
`ifdef FPGA_ROBOTS_UART_PARITY_EN
    next_baud(tag);
    chk({tag, "_par"}, 32'(txo(d)), 32'((^b) ^ (d == 2)));
`endif
    for (int s = 0; s < ((d == 2) ? 2 : 1); s++) begin
      next_baud(tag);
      chk($sformatf("%s_stop%0d", tag, s), 32'(txo(d)), 32'd1);
      chk($sformatf("%s_stopbusy%0d", tag, s), 32'(busyo(d)), 32'd1);
    end
  endtask

  task automatic wr1(input logic [7:0] b);
    wr_dat = b;
    wr_en  = 1'b1;
    clk1();
    wr_en  = 1'b0;
  endtask

  initial begin
    int zeros;
    int n;

    // Reset
    #1 rst_n = 1'b0;
    clk1();
    clk1();
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_wr_rdy", 32'(wr_rdy1), 32'd1);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    #2 rst_n = 1'b1;
    clk1();
    brun = 1'b1;
    bcnt = 0;

    // Single byte 0x55
    next_baud("sync1");
    wr1(8'h55);
    chk("t1_cnt", 32'(cnt1), 32'd1);
    chk("t1_busy", 32'(busy1), 32'd1);
    chk("t1_idle_tx", 32'(tx1), 32'd1);
    check_frame(1, 8'h55, 0, "t1");
    next_baud("t1_end");
    chk("t1_end_tx", 32'(tx1), 32'd1);
    chk("t1_end_busy", 32'(busy1), 32'd0);

    // Back-to-back 0xA5, 0x3C
    next_baud("sync2");
    wr1(8'hA5);
    chk("t2_cnt1", 32'(cnt1), 32'd1);
    wr1(8'h3C);
    chk("t2_cnt2", 32'(cnt1), 32'd2);
    check_frame(1, 8'hA5, 1, "t2a");
    check_frame(1, 8'h3C, 0, "t2b");
    next_baud("t2_end");
    chk("t2_end_tx", 32'(tx1), 32'd1);
    chk("t2_end_busy", 32'(busy1), 32'd0);

    // Overflow with baud stopped
    brun  = 1'b0;
    baud1 = 1'b0;
    clk1();
    for (int i = 0; i < 17; i++) begin
      wr1(8'(i));
      if (i == 14) chk("t3_rdy15", 32'(wr_rdy1), 32'd1);
      if (i == 15) begin
        chk("t3_rdy16", 32'(wr_rdy1), 32'd0);
        chk("t3_cnt16", 32'(cnt1), 32'd16);
        chk("t3_ovf16", 32'(ovf1), 32'd0);
      end
      if (i == 16) begin
        chk("t3_ovf17", 32'(ovf1), 32'd1);
        chk("t3_cnt17", 32'(cnt1), 32'd16);
      end
    end
    brun = 1'b1;
    bcnt = 0;
    for (int k = 0; k < 16; k++) check_frame(1, 8'(k), 15 - k, $sformatf("t3f%0d", k));
    next_baud("t3_end");
    chk("t3_end_tx", 32'(tx1), 32'd1);
    chk("t3_end_busy", 32'(busy1), 32'd0);
    chk("t3_end_ovf", 32'(ovf1), 32'd1);

    // Reset mid-frame: 0xFF plus five queued bytes, reset in data bit 3
    next_baud("sync4");
    wr1(8'hFF);
    for (int i = 1; i <= 5; i++) wr1(8'(i));
    next_baud("t4_start");
    chk("t4_start", 32'(tx1), 32'd0);
    for (int i = 0; i < 4; i++) next_baud("t4_bits");
    chk("t4_bit3", 32'(tx1), 32'd1);
    repeat (3) clk1();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_tx", 32'(tx1), 32'd1);
    chk("t4_async_cnt", 32'(cnt1), 32'd0);
    chk("t4_async_ovf", 32'(ovf1), 32'd0);
    chk("t4_async_busy", 32'(busy1), 32'd0);
    chk("t4_async_rdy", 32'(wr_rdy1), 32'd1);
    clk1();
    clk1();
    #2 rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 400; i++) begin
      clk1();
      if (tx1 !== 1'b1) zeros++;
    end
    chk("t4_no_frames", 32'(zeros), 32'd0);
    chk("t4_post_busy", 32'(busy1), 32'd0);

    // Reset during a start bit: tx must rise without a clock edge
    next_baud("sync4b");
    wr1(8'h5A);
    next_baud("t4b_start");
    chk("t4b_start", 32'(tx1), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t4b_async_tx", 32'(tx1), 32'd1);
    clk1();
    #2 rst_n = 1'b1;
    clk1();

    // Two stop bits (u_dut2); first write coincides with a baud1 strobe
    n = 0;
    while (!baud1 && n < 40) begin
      clk1();
      n++;
    end
    chk("t5_found_baud", 32'(baud1), 32'd1);
    wr1(8'h00);
    chk("t5_nopop_tx", 32'(tx2), 32'd1);
    chk("t5_nopop_cnt", 32'(cnt2), 32'd1);
    wr1(8'h00);
    chk("t5_cnt2", 32'(cnt2), 32'd2);
    check_frame(2, 8'h00, 1, "t5a");
    check_frame(2, 8'h00, 0, "t5b");
    next_baud("t5_end");
    chk("t5_end_tx", 32'(tx2), 32'd1);
    chk("t5_end_busy", 32'(busy2), 32'd0);

`ifdef FPGA_ROBOTS_UART_PARITY_EN
    // 0x07 has three ones: even parity bit 1 on u_dut1
    next_baud("sync6");
    wr1(8'h07);
    check_frame(1, 8'h07, 0, "t6");
    next_baud("t6_end");
    chk("t6_end_busy", 32'(busy1), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
